// File: rtl/txout_pkg.sv
// Shared types and sizing for the transducer output channel.
package txout_pkg;

    localparam int unsigned PHASE_W               = 16;
    localparam int unsigned CHARGE_W              = 9;
    localparam int unsigned MAX_ON_CYCLES_DEFAULT = 256;

    typedef enum logic [2:0] {
        TXOUT_IDLE   = 3'd0,
        TXOUT_ARMED  = 3'd1,
        TXOUT_DELAY  = 3'd2,
        TXOUT_CHARGE = 3'd3,
        TXOUT_DONE   = 3'd4
    } txoutState_e;

endpackage

// File: rtl/txout_downcounter.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module txout_downcounter
    import txout_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dec,
    input  logic [PHASE_W-1:0] loadValue,
    output logic [PHASE_W-1:0] count,
    output logic               zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec && (count != '0)) begin
            count <= count - PHASE_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/transducer_output_channel.sv
// Single-channel arm/trigger/delay/charge pulse generator.
// Optional on-time watchdog: define TXOUT_SAFETY_WATCHDOG_EN.
module transducer_output_channel
    import txout_pkg::*;
#(
    parameter int unsigned MAX_ON_CYCLES = MAX_ON_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mask,
    input  logic                onYourMark,
    input  logic                GOGOGO_EXCLAMATION,
    input  logic [CHARGE_W-1:0] chargeTime,
    input  logic [PHASE_W-1:0]  phaseDelay,
    output logic                transducerOutput,
    output logic                fireComplete,
    output logic                warning
);

    txoutState_e         state;
    logic [PHASE_W-1:0]  phaseLatch;
    logic [CHARGE_W-1:0] chargeLatch;
    logic                maskLatch;

    logic                cntLoad;
    logic                cntDec;
    logic [PHASE_W-1:0]  cntLoadValue;
    logic [PHASE_W-1:0]  cntValue;
    logic                cntZero;
    logic                chargeEnd;
    logic                wdTrip;

    txout_downcounter u_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (cntLoad),
        .dec       (cntDec),
        .loadValue (cntLoadValue),
        .count     (cntValue),
        .zero      (cntZero)
    );

    // One counter serves both phases: phase delay on trigger, charge time when delay expires.
    always_comb begin
        cntLoad      = 1'b0;
        cntDec       = 1'b0;
        cntLoadValue = '0;
        case (state)
            TXOUT_ARMED: begin
                if (onYourMark && GOGOGO_EXCLAMATION) begin
                    cntLoad      = 1'b1;
                    cntLoadValue = phaseLatch;
                end
            end
            TXOUT_DELAY: begin
                if (cntZero) begin
                    cntLoad      = 1'b1;
                    cntLoadValue = PHASE_W'(chargeLatch);
                end else begin
                    cntDec = 1'b1;
                end
            end
            TXOUT_CHARGE: cntDec = 1'b1;
            default: ;
        endcase
    end

    assign chargeEnd = (state == TXOUT_CHARGE) && (cntValue == PHASE_W'(1));

`ifdef TXOUT_SAFETY_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(MAX_ON_CYCLES + 1);

    logic [WD_W-1:0] onCount;

    // onCount holds the number of completed high cycles before the current edge.
    assign wdTrip = transducerOutput && (onCount == WD_W'(MAX_ON_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !transducerOutput || wdTrip) begin
            onCount <= '0;
        end else begin
            onCount <= onCount + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warning <= 1'b0;
        end else if (wdTrip) begin
            warning <= 1'b1;
        end
    end
`else
    assign wdTrip  = 1'b0;
    assign warning = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= TXOUT_IDLE;
            transducerOutput <= 1'b0;
            fireComplete     <= 1'b0;
            phaseLatch       <= '0;
            chargeLatch      <= '0;
            maskLatch        <= 1'b0;
        end else begin
            case (state)
                TXOUT_IDLE: begin
                    transducerOutput <= 1'b0;
                    if (onYourMark) begin
                        phaseLatch  <= phaseDelay;
                        chargeLatch <= chargeTime;
                        maskLatch   <= mask;
                        state       <= TXOUT_ARMED;
                    end
                end
                TXOUT_ARMED: begin
                    transducerOutput <= 1'b0;
                    if (!onYourMark) begin
                        state <= TXOUT_IDLE;
                    end else if (GOGOGO_EXCLAMATION) begin
                        state <= TXOUT_DELAY;
                    end
                end
                TXOUT_DELAY: begin
                    if (cntZero) begin
                        if (chargeLatch == '0) begin
                            state        <= TXOUT_DONE;
                            fireComplete <= 1'b1;
                        end else begin
                            state            <= TXOUT_CHARGE;
                            transducerOutput <= maskLatch;
                        end
                    end
                end
                TXOUT_CHARGE: begin
                    if (chargeEnd || wdTrip) begin
                        state            <= TXOUT_DONE;
                        transducerOutput <= 1'b0;
                        fireComplete     <= 1'b1;
                    end
                end
                TXOUT_DONE: begin
                    transducerOutput <= 1'b0;
                    fireComplete     <= 1'b1;
                end
                default: begin
                    state            <= TXOUT_IDLE;
                    transducerOutput <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transducer_output_channel.sv
// Scoreboard bench for transducer_output_channel: expected per-cycle outputs queued at stimulus time.
module tb_transducer_output_channel;

    localparam int unsigned WD_MAX = 256;

    typedef struct {
        logic out;
        logic fc;
        logic warn;
    } expEntry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mask = 1'b0;
    logic        onYourMark = 1'b0;
    logic        GOGOGO_EXCLAMATION = 1'b0;
    logic [8:0]  chargeTime = '0;
    logic [15:0] phaseDelay = '0;
    logic        transducerOutput;
    logic        fireComplete;
    logic        warning;

    int checks   = 0;
    int failures = 0;
    expEntry_t sb[$];

    transducer_output_channel #(
        .MAX_ON_CYCLES (WD_MAX)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .mask               (mask),
        .onYourMark         (onYourMark),
        .GOGOGO_EXCLAMATION (GOGOGO_EXCLAMATION),
        .chargeTime         (chargeTime),
        .phaseDelay         (phaseDelay),
        .transducerOutput   (transducerOutput),
        .fireComplete       (fireComplete),
        .warning            (warning)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            expEntry_t e;
            e = sb.pop_front();
            checkValue("transducerOutput", 32'(transducerOutput), 32'(e.out));
            checkValue("fireComplete", 32'(fireComplete), 32'(e.fc));
            checkValue("warning", 32'(warning), 32'(e.warn));
        end
    end

    task automatic pushExp(input logic o, input logic f, input logic w);
        expEntry_t e;
        e.out  = o;
        e.fc   = f;
        e.warn = w;
        sb.push_back(e);
    endtask

    task automatic waitDrain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        checkValue("scoreboardDrain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic doReset();
        rst = 1'b1;
        onYourMark = 1'b0;
        GOGOGO_EXCLAMATION = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Arms, triggers at edge k, then queues the expected outputs for edges k..k+n.
    task automatic fireRun(input logic m, input int pd, input int ct, input int n);
        int effCt;
        logic warnExp;
        doReset();
        mask = m;
        phaseDelay = 16'(pd);
        chargeTime = 9'(ct);
        onYourMark = 1'b1;
        @(posedge clk);
        #1;
        GOGOGO_EXCLAMATION = 1'b1;
        @(posedge clk);
        #1;
        GOGOGO_EXCLAMATION = 1'b0;
        effCt = ct;
        warnExp = 1'b0;
`ifdef TXOUT_SAFETY_WATCHDOG_EN
        if (m && ct >= int'(WD_MAX)) begin
            effCt = int'(WD_MAX);
            warnExp = 1'b1;
        end
`endif
        for (int j = 0; j <= n; j++) begin
            pushExp(m && (j >= pd + 1) && (j < pd + 1 + effCt),
                    (j >= pd + 1 + effCt),
                    warnExp && (j >= pd + 1 + effCt));
        end
        waitDrain(n + 5);
    endtask

    initial begin
        doReset();
        @(negedge clk);
        checkValue("resetOutput", 32'(transducerOutput), 32'd0);
        checkValue("resetFireComplete", 32'(fireComplete), 32'd0);
        checkValue("resetWarning", 32'(warning), 32'd0);

        fireRun(1'b1, 5, 9, 20);
        fireRun(1'b0, 5, 9, 20);
        fireRun(1'b1, 0, 0, 6);
        fireRun(1'b1, 0, 1, 6);
        fireRun(1'b1, 300, 3, 310);

        // Abort: arm, drop onYourMark, then trigger must be ignored.
        doReset();
        mask = 1'b1;
        phaseDelay = 16'd2;
        chargeTime = 9'd4;
        onYourMark = 1'b1;
        @(posedge clk);
        #1;
        onYourMark = 1'b0;
        @(posedge clk);
        #1;
        GOGOGO_EXCLAMATION = 1'b1;
        for (int j = 0; j < 10; j++) pushExp(1'b0, 1'b0, 1'b0);
        waitDrain(15);
        GOGOGO_EXCLAMATION = 1'b0;

        // Reset asserted mid-charge, with onYourMark still high.
        doReset();
        mask = 1'b1;
        phaseDelay = 16'd2;
        chargeTime = 9'd20;
        onYourMark = 1'b1;
        @(posedge clk);
        #1;
        GOGOGO_EXCLAMATION = 1'b1;
        @(posedge clk);
        #1;
        GOGOGO_EXCLAMATION = 1'b0;
        for (int j = 0; j <= 6; j++) pushExp(j >= 3, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int j = 0; j < 3; j++) pushExp(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        onYourMark = 1'b0;
        waitDrain(10);

        fireRun(1'b1, 3, 400, 412);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL globalTimeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/transducer_output_channel.md
# transducer_output_channel

Single-channel pulse generator for the transmit path: arms on a fire request, waits for the shared external trigger, then drives one transducer drive line high for a programmed charge time after a programmed phase delay. Eight copies sit under the output control block, one per transducer element. Their `fireComplete` flags are ANDed to release the next fire, and their `warning` flags are ORed into the emergency path.

## Interface
- `MAX_ON_CYCLES`, default 256: hard ceiling on consecutive high cycles of `transducerOutput`; only used when the watchdog is compiled in.
- `clk` in 1: transmit clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mask` in 1: channel enable; 0 keeps the output low, but the sequence still runs and completes.
- `onYourMark` in 1: arm request (level).
- `GOGOGO_EXCLAMATION` in 1: external fire trigger (level, sampled).
- `chargeTime` in 9: pulse width in clk cycles; 0 means no pulse.
- `phaseDelay` in 16: cycles from trigger sample to pulse start.
- `transducerOutput` out 1: drive line, registered.
- `fireComplete` out 1: sticky done flag.
- `warning` out 1: sticky safety fault.

## Operation
- States: IDLE, ARMED, DELAY, CHARGE, DONE.
- IDLE:
  - `onYourMark`=1 moves to ARMED and latches `phaseDelay`, `chargeTime` and `mask`.
  - Inputs are ignored in all other states.
- ARMED:
  - `onYourMark`=0 aborts back to IDLE.
  - Otherwise, `GOGOGO_EXCLAMATION`=1 moves to DELAY with counter = latched `phaseDelay`.
- DELAY:
  - Counter decrements each cycle.
  - When the counter is 0, the next state is CHARGE with counter = `chargeTime`, or DONE if `chargeTime`=0.
- CHARGE:
  - Output = latched mask.
  - Counter decrements; at 1 → DONE.
- DONE:
  - Output low, `fireComplete`=1.
  - Held until `rst`; `onYourMark` is ignored.
- Output is never high outside CHARGE. A masked channel is silent but still reaches DONE.
- Counters are unsigned and must not wrap; a 16-bit delay up to 65535 is valid.
- Reset mid-operation drops the output low on the same edge and returns to IDLE.
- If `rst` and `onYourMark` are both high, `rst` wins.

## Timing
- Reset values: `transducerOutput`=0, `fireComplete`=0, `warning`=0, state IDLE.
- Arm latency: 1 cycle (`onYourMark` sampled at edge a → ARMED after a). Trigger is honoured from edge a+1.
- Trigger sampled high at edge k:
  - Output rises at edge k+1+phaseDelay.
  - Output stays high exactly chargeTime cycles.
  - Output falls at edge k+1+phaseDelay+chargeTime, and `fireComplete` rises at that same edge.
- With `chargeTime`=0, `fireComplete` rises at edge k+1+phaseDelay and the output never rises.

## Configuration
- `TXOUT_SAFETY_WATCHDOG_EN` defined:
  - An independent counter tracks consecutive high cycles of `transducerOutput`.
  - On reaching `MAX_ON_CYCLES`, the output is forced low on that edge, `warning` is set (sticky until `rst`) and the state goes to DONE.
  - So a chargeTime above the limit yields a pulse of exactly `MAX_ON_CYCLES` cycles plus a warning.
- Undefined: `warning` is tied 0; the pulse width is chargeTime only.

## Structure
- Shared package `txout_pkg`: state enum, `PHASE_W`=16, `CHARGE_W`=9, default `MAX_ON_CYCLES`.
- One natural sub-module, `txout_downcounter`: a loadable 16-bit down-counter with zero flag, reused for the delay and charge phases.
- Watchdog logic stays inline under the macro.

## Test plan
- Fire, enabled: rst, mask=1, phaseDelay=5, chargeTime=9, onYourMark=1, trigger at edge k → output high on edges k+6..k+15 exclusive (9 cycles); `fireComplete`=1 from k+15; `warning`=0.
- Masked channel: mask=0, same stimulus → output stays 0; `fireComplete` still rises at k+15.
- Zero charge / zero delay: phaseDelay=0, chargeTime=0 → no pulse, `fireComplete` at k+1. Separately, chargeTime=1 → one-cycle pulse at k+1.
- Abort and reset: arm, drop `onYourMark` before the trigger → IDLE, trigger ignored, no pulse. Assert `rst` mid-CHARGE → output 0 on the same edge, `fireComplete`=0.
- Watchdog (macro defined, `MAX_ON_CYCLES`=256): chargeTime=400 → pulse of exactly 256 cycles, then `warning`=1 and `fireComplete`=1, both sticky until rst. With the macro undefined, same stimulus → a 400-cycle pulse and `warning`=0.
